// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Round-robin arbiter sharing one word-wide data memory between
//                the CPU load/store stage (req 0) and the debug/DMA port (req 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_we,
    input  logic [1:0][1:0]            req_size,
    input  logic [1:0]                 req_unsigned,
    input  logic [1:0][ADDR_WIDTH+1:0] req_addr,
    input  logic [1:0][31:0]           req_wdata,
    output logic [1:0]                 rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic                       mem_wen,
    output logic [ADDR_WIDTH-1:0]      mem_write_addr,
    output logic [31:0]                mem_write_data,
    output logic [ADDR_WIDTH-1:0]      mem_read_addr,
    input  logic [31:0]                mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2
    } state_t;

    localparam logic [1:0] c_sz_byte = 2'b00;
    localparam logic [1:0] c_sz_half = 2'b01;
    localparam logic [1:0] c_sz_word = 2'b10;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_last_grant;
    logic                    r_id;
    logic                    r_we;
    logic                    r_unsigned;
    logic [1:0]              r_size;
    logic [ADDR_WIDTH+1:0]   r_addr;
    logic [31:0]             r_wdata;
    logic [31:0]             r_merge;
    logic [1:0]              r_rsp_valid;
    logic [31:0]             r_rsp_rdata;
    logic                    r_rsp_err;

    logic [1:0]              w_grant;
    logic                    w_accept;
    logic                    w_gid;
    logic                    w_err;
    logic                    w_word_store;
    logic                    w_sub_store;
    logic [31:0]             w_lane;
    logic [31:0]             w_load_data;
    logic [31:0]             w_merged;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        w_grant = 2'b00;
        if (r_state == S_IDLE) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign req_ready = w_grant;
    assign w_accept  = |w_grant;
    assign w_gid     = w_grant[1];

    assign w_err = (r_size == 2'b11)
                 | ((r_size == c_sz_half) & r_addr[0])
                 | ((r_size == c_sz_word) & (r_addr[1:0] != 2'b00));

    assign w_word_store = r_we & ~w_err & (r_size == c_sz_word);
    assign w_sub_store  = r_we & ~w_err & (r_size != c_sz_word);

    assign w_lane = mem_read_data >> {r_addr[1:0], 3'b000};

    always_comb begin
        case (r_size)
            c_sz_byte: w_load_data = {{24{~r_unsigned & w_lane[7]}},  w_lane[7:0]};
            c_sz_half: w_load_data = {{16{~r_unsigned & w_lane[15]}}, w_lane[15:0]};
            default:   w_load_data = mem_read_data;
        endcase
    end

    // Replace only the addressed lanes of the word read back during ACCESS.
    always_comb begin
        w_merged = r_merge;
        for (int b = 0; b < 4; b++) begin
            if ((r_size == c_sz_byte) && (r_addr[1:0] == b[1:0]))
                w_merged[8*b +: 8] = r_wdata[7:0];
            if ((r_size == c_sz_half) && (r_addr[1] == b[1]))
                w_merged[8*b +: 8] = b[0] ? r_wdata[15:8] : r_wdata[7:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = w_sub_store ? S_WRITE : S_IDLE;
            S_WRITE:  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Write enable decoded from state so an async reset kills it at once.
    assign mem_wen        = ((r_state == S_ACCESS) & w_word_store) | (r_state == S_WRITE);
    assign mem_write_addr = r_addr[ADDR_WIDTH+1:2];
    assign mem_read_addr  = r_addr[ADDR_WIDTH+1:2];
    assign mem_write_data = (r_state == S_WRITE) ? w_merged : r_wdata;

    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_we         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= 2'b00;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_merge      <= 32'd0;
            r_rsp_valid  <= 2'b00;
            r_rsp_rdata  <= 32'd0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= 2'b00;
            if (w_accept) begin
                r_id         <= w_gid;
                r_we         <= req_we[w_gid];
                r_size       <= req_size[w_gid];
                r_unsigned   <= req_unsigned[w_gid];
                r_addr       <= req_addr[w_gid];
                r_wdata      <= req_wdata[w_gid];
                r_last_grant <= w_gid;
            end
            if (r_state == S_ACCESS) begin
                if (w_sub_store) begin
                    r_merge <= mem_read_data;
                end else begin
                    r_rsp_valid <= {r_id, ~r_id};
                    r_rsp_rdata <= (r_we | w_err) ? 32'd0 : w_load_data;
                    r_rsp_err   <= w_err;
                end
            end
            if (r_state == S_WRITE) begin
                r_rsp_valid <= {r_id, ~r_id};
                r_rsp_rdata <= 32'd0;
                r_rsp_err   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter (vector table, directed
//                corner cases and randomized traffic against a byte-level model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW = 12;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [1:0]           req_valid = '0;
    logic [1:0]           req_ready;
    logic [1:0]           req_we = '0;
    logic [1:0][1:0]      req_size = '0;
    logic [1:0]           req_unsigned = '0;
    logic [1:0][AW+1:0]   req_addr = '0;
    logic [1:0][31:0]     req_wdata = '0;
    logic [1:0]           rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 mem_wen;
    logic [AW-1:0]        mem_write_addr;
    logic [31:0]          mem_write_data;
    logic [AW-1:0]        mem_read_addr;
    logic [31:0]          mem_read_data;

    logic                 pre_en = 1'b0;
    logic [AW-1:0]        pre_addr = '0;
    logic [31:0]          pre_data = '0;
    logic [31:0]          mem [0:(1<<AW)-1];
    logic [31:0]          ref_mem [0:7];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_wen(mem_wen), .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data)
    );

    assign mem_read_data = mem[mem_read_addr];

    always @(posedge clk) begin
        if (mem_wen)
            mem[mem_write_addr] <= mem_write_data;
        else if (pre_en)
            mem[pre_addr] <= pre_data;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic preload(input int w, input logic [31:0] d);
        @(negedge clk);
        pre_en   = 1'b1;
        pre_addr = w[AW-1:0];
        pre_data = d;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic drive(input int id, input logic we, input logic [1:0] sz,
                         input logic uns, input logic [AW+1:0] a, input logic [31:0] wd);
        req_we[id]       = we;
        req_size[id]     = sz;
        req_unsigned[id] = uns;
        req_addr[id]     = a;
        req_wdata[id]    = wd;
        req_valid[id]    = 1'b1;
    endtask

    // Wait for the handshake of requester id, then collect response timing.
    // lat counts negedges after the accepting posedge (-1 = no response seen).
    task automatic run_txn(input int id, output int lat, output logic [1:0] rv,
                           output logic [31:0] rd, output logic er,
                           output int wmask, output int busy_rdy);
        int t;
        t = 0;
        lat = -1; rv = 2'b00; rd = 32'd0; er = 1'b0; wmask = 0; busy_rdy = 0;
        #1;
        while (req_ready[id] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) begin
            req_valid[id] = 1'b0;
            return;
        end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req_valid[id] = 1'b0;
            if (mem_wen) wmask |= (1 << k);
            if (rsp_valid != 2'b00) begin
                lat = k; rv = rsp_valid; rd = rsp_rdata; er = rsp_err;
                break;
            end
            if (req_ready != 2'b00) busy_rdy = 1;
        end
    endtask

    // Byte-level reference: what the memory word and load result must be.
    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [AW+1:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er,
                         output int lat, output int wm);
        int w, off, nb;
        logic [63:0] v;
        w   = int'(a) / 4;
        off = int'(a) % 4;
        er  = (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
        rd = 32'd0; lat = 2; wm = 0;
        if (er) return;
        nb = 1 << sz;
        if (!we) begin
            v = {32'd0, ref_mem[w]} >> (8 * off);
            v = v & ((64'd1 << (8 * nb)) - 64'd1);
            if (!uns && nb < 4 && v[8*nb-1]) v = v - (64'd1 << (8 * nb));
            rd = v[31:0];
        end else begin
            for (int i = 0; i < nb; i++)
                ref_mem[w][8*(off+i) +: 8] = wd[8*i +: 8];
            if (nb == 4) wm = 2;
            else begin wm = 4; lat = 3; end
        end
    endtask

    typedef struct {
        int          id;
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [13:0] a;
        logic [31:0] wd;
        logic [31:0] pre;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_wm;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int lat, wmask, busy, g, wm_e, lat_e, last;
        logic [1:0] rv;
        logic [31:0] rd, rd_e;
        logic er, er_e;
        int gid_q[$];
        int gcy_q[$];
        logic [1:0] rvh [0:39];
        bit pv [2];
        logic p_we [2];
        logic [1:0] p_sz [2];
        logic p_uns [2];
        logic [AW+1:0] p_a [2];
        logic [31:0] p_wd [2];

        vecs[0]  = '{0, 1'b1, 2'd2, 1'b0, 14'h010, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 1'b0, 2, 2, 32'hDEADBEEF};
        vecs[1]  = '{1, 1'b0, 2'd0, 1'b0, 14'h013, 32'h00000000, 32'h80FF1234, 32'hFFFFFF80, 1'b0, 2, 0, 32'h80FF1234};
        vecs[2]  = '{1, 1'b0, 2'd0, 1'b1, 14'h013, 32'h00000000, 32'h80FF1234, 32'h00000080, 1'b0, 2, 0, 32'h80FF1234};
        vecs[3]  = '{0, 1'b1, 2'd1, 1'b0, 14'h012, 32'h0000ABCD, 32'h11223344, 32'h00000000, 1'b0, 3, 4, 32'hABCD3344};
        vecs[4]  = '{0, 1'b0, 2'd2, 1'b0, 14'h006, 32'h00000000, 32'h12345678, 32'h00000000, 1'b1, 2, 0, 32'h12345678};
        vecs[5]  = '{1, 1'b1, 2'd3, 1'b0, 14'h008, 32'hFFFFFFFF, 32'h0BADF00D, 32'h00000000, 1'b1, 2, 0, 32'h0BADF00D};
        vecs[6]  = '{0, 1'b0, 2'd1, 1'b0, 14'h002, 32'h00000000, 32'h80017FFF, 32'hFFFF8001, 1'b0, 2, 0, 32'h80017FFF};
        vecs[7]  = '{1, 1'b0, 2'd1, 1'b1, 14'h000, 32'h00000000, 32'h80017FFF, 32'h00007FFF, 1'b0, 2, 0, 32'h80017FFF};
        vecs[8]  = '{1, 1'b1, 2'd0, 1'b0, 14'h021, 32'hFFFFFF5A, 32'h11223344, 32'h00000000, 1'b0, 3, 4, 32'h11225A44};
        vecs[9]  = '{0, 1'b1, 2'd1, 1'b0, 14'h023, 32'h00001234, 32'h55667788, 32'h00000000, 1'b1, 2, 0, 32'h55667788};
        vecs[10] = '{1, 1'b0, 2'd2, 1'b0, 14'h01C, 32'h00000000, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 2, 0, 32'hCAFEF00D};
        vecs[11] = '{0, 1'b0, 2'd0, 1'b0, 14'h100, 32'h00000000, 32'h000000FE, 32'hFFFFFFFE, 1'b0, 2, 0, 32'h000000FE};
        vecs[12] = '{0, 1'b1, 2'd0, 1'b0, 14'h030, 32'h000000AA, 32'hFFFFFFFF, 32'h00000000, 1'b0, 3, 4, 32'hFFFFFFAA};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("reset_mem_wen", {31'd0, mem_wen}, 32'd0);
        rst_n = 1'b1;

        // Vector table
        for (int i = 0; i < 13; i++) begin
            preload(int'(vecs[i].a) / 4, vecs[i].pre);
            @(negedge clk);
            drive(vecs[i].id, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd);
            run_txn(vecs[i].id, lat, rv, rd, er, wmask, busy);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_rsp_valid", i), {30'd0, rv}, 32'd1 << vecs[i].id);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_wen_cycles", i), wmask, vecs[i].exp_wm);
            chk($sformatf("v%0d_ready_busy", i), busy, 0);
            chk($sformatf("v%0d_mem_word", i), mem[int'(vecs[i].a) / 4], vecs[i].exp_mem);
        end

        // Both requesters valid continuously from reset: grants alternate
        do_reset();
        @(negedge clk);
        drive(0, 1'b0, 2'd2, 1'b0, 14'h000, 32'd0);
        drive(1, 1'b0, 2'd2, 1'b0, 14'h004, 32'd0);
        #1;
        for (int c = 0; c < 40; c++) begin
            rvh[c] = rsp_valid;
            if (req_ready != 2'b00) begin
                chk($sformatf("alt_onehot_c%0d", c), {30'd0, req_ready},
                    req_ready[1] ? 32'd2 : 32'd1);
                gid_q.push_back(int'(req_ready[1]));
                gcy_q.push_back(c);
            end
            @(negedge clk);
            #1;
        end
        req_valid = 2'b00;
        chk("alt_grant_count", gid_q.size(), 20);
        for (int i = 0; i < gid_q.size() && i < 8; i++) begin
            chk($sformatf("alt_grant%0d", i), gid_q[i], i % 2);
            if (i > 0) chk($sformatf("alt_spacing%0d", i), gcy_q[i] - gcy_q[i-1], 2);
            if (gcy_q[i] + 2 < 40)
                chk($sformatf("alt_rsp%0d", i), {30'd0, rvh[gcy_q[i]+2]}, 32'd1 << gid_q[i]);
        end

        // Reset asserted during the WRITE cycle of a half store
        do_reset();
        preload(14'h050 >> 2, 32'h11223344);
        @(negedge clk);
        drive(0, 1'b1, 2'd1, 1'b0, 14'h050, 32'h0000BEEF);
        #1;
        chk("rstw_ready", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        chk("rstw_wen_access", {31'd0, mem_wen}, 32'd0);
        @(negedge clk);
        chk("rstw_wen_write", {31'd0, mem_wen}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rstw_wen_dropped", {31'd0, mem_wen}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rstw_no_rsp%0d", c), {30'd0, rsp_valid}, 32'd0);
        end
        chk("rstw_mem_untouched", mem[14'h050 >> 2], 32'h11223344);
        drive(0, 1'b0, 2'd2, 1'b0, 14'h000, 32'd0);
        drive(1, 1'b0, 2'd2, 1'b0, 14'h000, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rstw_first_grant", {30'd0, req_ready}, 32'd1);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        chk("rstw_no_rsp_after", {30'd0, rsp_valid}, 32'd0);

        // Randomized traffic against the reference model
        do_reset();
        for (int w = 0; w < 8; w++) begin
            ref_mem[w] = $urandom;
            preload(w, ref_mem[w]);
        end
        @(negedge clk);
        last = 1;
        pv[0] = 0; pv[1] = 0;
        for (int n = 0; n < 200; n++) begin
            for (int id = 0; id < 2; id++) begin
                if (!pv[id] && ($urandom % 10) < 6) pv[id] = 1;
                else continue;
                p_we[id]  = 1'($urandom % 2);
                p_sz[id]  = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
                p_uns[id] = 1'($urandom % 2);
                p_a[id]   = 14'($urandom % 32);
                p_wd[id]  = $urandom;
                drive(id, p_we[id], p_sz[id], p_uns[id], p_a[id], p_wd[id]);
            end
            if (!pv[0] && !pv[1]) begin
                g = int'($urandom % 2);
                pv[g] = 1;
                p_we[g] = 1'b0; p_sz[g] = 2'd2; p_uns[g] = 1'b0;
                p_a[g] = 14'(($urandom % 8) * 4); p_wd[g] = 32'd0;
                drive(g, p_we[g], p_sz[g], p_uns[g], p_a[g], p_wd[g]);
            end
            g = (pv[0] && pv[1]) ? (last == 1 ? 0 : 1) : (pv[0] ? 0 : 1);
            #1;
            chk($sformatf("rnd%0d_grant", n), {30'd0, req_ready}, 32'd1 << g);
            model(p_we[g], p_sz[g], p_uns[g], p_a[g], p_wd[g], rd_e, er_e, lat_e, wm_e);
            run_txn(g, lat, rv, rd, er, wmask, busy);
            chk($sformatf("rnd%0d_latency", n), lat, lat_e);
            chk($sformatf("rnd%0d_rsp_valid", n), {30'd0, rv}, 32'd1 << g);
            chk($sformatf("rnd%0d_rdata", n), rd, rd_e);
            chk($sformatf("rnd%0d_err", n), {31'd0, er}, {31'd0, er_e});
            chk($sformatf("rnd%0d_wen_cycles", n), wmask, wm_e);
            chk($sformatf("rnd%0d_ready_busy", n), busy, 0);
            last = g;
            pv[g] = 0;
        end
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 8; w++)
            chk($sformatf("rnd_mem_word%0d", w), mem[w], ref_mem[w]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
